// File: rtl/pq_pop_stream.sv
// Pops the priority-queue head whenever it is eligible (enabled, present, key <= thresh) into a 2-entry output buffer.
// Pop-to-valid latency is one cycle; pops stall only when the buffer is full and m_ready is low.
module pq_pop_stream #(
  parameter int KW = 4,
  parameter int VW = 4,
  parameter int CW = 16,
  parameter logic [KW-1:0] KEYINF = {KW{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KW+VW-1:0] pq_kvo,
  input  logic             pq_empty,
  output logic             pq_pop,
  input  logic             en,
  input  logic [KW-1:0]    thresh,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [KW+VW-1:0] m_kv,
  output logic [CW-1:0]    pop_count
);

  localparam int DW = KW + VW;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] ent0, ent1;
  logic [DW-1:0] ent0_nxt, ent1_nxt;
  logic [KW-1:0] head_key;
  logic          eligible;
  logic          deq;

  assign head_key = pq_kvo[DW-1:VW];
  assign eligible = en && !pq_empty && (head_key != KEYINF) && (head_key <= thresh);

  assign m_valid = (state != S0);
  assign m_kv    = ent0;
  assign deq     = m_valid && m_ready;

  // When full, a pop is only safe if the consumer frees a slot this same cycle.
  assign pq_pop = rst && eligible && ((state != S2) || m_ready) && !flush;

  always_comb begin
    state_nxt = state;
    ent0_nxt  = ent0;
    ent1_nxt  = ent1;
    case (state)
      S0: begin
        if (pq_pop) begin
          ent0_nxt  = pq_kvo;
          state_nxt = S1;
        end
      end
      S1: begin
        if (pq_pop && deq) begin
          ent0_nxt = pq_kvo;
        end else if (pq_pop) begin
          ent1_nxt  = pq_kvo;
          state_nxt = S2;
        end else if (deq) begin
          state_nxt = S0;
        end
      end
      S2: begin
        if (deq) begin
          ent0_nxt = ent1;
          if (pq_pop) begin
            ent1_nxt = pq_kvo;
          end else begin
            state_nxt = S1;
          end
        end
      end
      default: state_nxt = S0;
    endcase
    if (flush) begin
      state_nxt = S0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      state <= state_nxt;
      ent0  <= ent0_nxt;
      ent1  <= ent1_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_count <= '0;
    end else if (pq_pop) begin
      pop_count <= pop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pq_pop_stream.sv
// Bench for pq_pop_stream: a sorted-queue environment feeds the head; a FIFO-level model predicts the outputs.
module tb_pq_pop_stream;
  localparam int KW = 4;
  localparam int VW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    pq_kvo = 8'hF0;
  logic          pq_empty = 1'b1;
  logic          pq_pop;
  logic          en = 1'b0;
  logic [3:0]    thresh = 4'd0;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    m_kv;
  logic [CW-1:0] pop_count;

  always #5 clk = ~clk;

  pq_pop_stream #(.KW(KW), .VW(VW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .pq_kvo(pq_kvo), .pq_empty(pq_empty), .pq_pop(pq_pop),
    .en(en), .thresh(thresh), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_kv(m_kv), .pop_count(pop_count)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] envq[$];    // queue contents, lowest key first
  logic [7:0] mq[$];      // expected output buffer contents, oldest first
  logic [7:0] outlog[$];  // pairs the model says were handed downstream
  int         mcnt = 0;
  int         pop_cycles = 0;
  logic       env_pop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic present();
    pq_empty = (envq.size() == 0);
    pq_kvo   = pq_empty ? 8'hF0 : envq[0];
  endtask

  task automatic push(input logic [7:0] kv);
    int i = 0;
    while (i < envq.size() && envq[i][7:4] <= kv[7:4]) i++;
    envq.insert(i, kv);
    present();
  endtask

  function automatic logic model_pop();
    logic elig;
    elig = en && !pq_empty && (pq_kvo[7:4] != 4'hF) && (pq_kvo[7:4] <= thresh);
    return elig && (mq.size() < 2 || m_ready) && !flush;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("pq_pop", pq_pop, model_pop());
      check("m_valid", m_valid, mq.size() != 0);
      if (mq.size() != 0) check("m_kv", m_kv, mq[0]);
      check("pop_count", pop_count, mcnt & 32'hFFFF);
    end
  end

  always @(posedge clk or negedge rst) begin
    logic p, d;
    if (!rst) begin
      mq.delete();
      mcnt    = 0;
      env_pop = 1'b0;
    end else begin
      p = model_pop();
      d = (mq.size() != 0) && m_ready;
      env_pop = pq_pop;
      if (pq_pop) pop_cycles++;
      if (flush) begin
        mq.delete();
      end else begin
        if (d) outlog.push_back(mq.pop_front());
        if (p) mq.push_back(pq_kvo);
      end
      if (p) mcnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (env_pop && envq.size() != 0) void'(envq.pop_front());
      env_pop = 1'b0;
      present();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    envq.delete();
    present();
    en = 1'b0; flush = 1'b0; m_ready = 1'b0; thresh = 4'd0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_kv", m_kv, 0);
    check("rst_pop_count", pop_count, 0);
    cyc(2);
    rst = 1'b1;
    outlog.delete();
    pop_cycles = 0;
  endtask

  initial begin
    // Basic drain
    do_reset();
    push(8'h31); push(8'h93); push(8'h52);
    en = 1'b1; thresh = 4'd15; m_ready = 1'b1;
    cyc(6);
    check("drain_pop_cycles", pop_cycles, 3);
    check("drain_out_n", outlog.size(), 3);
    if (outlog.size() == 3) begin
      check("drain_out0", outlog[0], 8'h31);
      check("drain_out1", outlog[1], 8'h52);
      check("drain_out2", outlog[2], 8'h93);
    end
    check("drain_count", pop_count, 3);
    check("drain_idle", m_valid, 0);

    // Threshold gating
    do_reset();
    push(8'h2A); push(8'h7B);
    en = 1'b1; thresh = 4'd4; m_ready = 1'b1;
    cyc(4);
    check("thr_count_low", pop_count, 1);
    check("thr_pop_blocked", pq_pop, 0);
    thresh = 4'd7;
    #1;
    check("thr_pop_now", pq_pop, 1);
    cyc(3);
    check("thr_count", pop_count, 2);
    if (outlog.size() == 2) check("thr_out1", outlog[1], 8'h7B);
    else check("thr_out_n", outlog.size(), 2);

    // Backpressure
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1; thresh = 4'd15; m_ready = 1'b0;
    cyc(4);
    check("bp_count", pop_count, 2);
    check("bp_pop_held", pq_pop, 0);
    check("bp_head", m_kv, 8'h11);
    m_ready = 1'b1;
    #1;
    check("bp_pop_full", pq_pop, 1);
    cyc(5);
    check("bp_out_n", outlog.size(), 3);
    if (outlog.size() == 3) begin
      check("bp_out0", outlog[0], 8'h11);
      check("bp_out1", outlog[1], 8'h22);
      check("bp_out2", outlog[2], 8'h33);
    end

    // Flush
    do_reset();
    push(8'h44); push(8'h66); push(8'h88);
    en = 1'b1; thresh = 4'd15; m_ready = 1'b0;
    cyc(3);
    check("fl_count_pre", pop_count, 2);
    flush = 1'b1; m_ready = 1'b1;
    #1;
    check("fl_pop_blocked", pq_pop, 0);
    cyc(1);
    flush = 1'b0; m_ready = 1'b0; en = 1'b0;
    #1;
    check("fl_valid", m_valid, 0);
    check("fl_count", pop_count, 2);
    cyc(2);

    // Empty queue, then a KEYINF head
    do_reset();
    en = 1'b1; thresh = 4'd15; m_ready = 1'b1;
    cyc(3);
    push(8'hF5);
    cyc(3);
    check("inf_pop_cycles", pop_cycles, 0);
    check("inf_count", pop_count, 0);
    check("inf_valid", m_valid, 0);

    // Asynchronous reset mid-stream
    do_reset();
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    en = 1'b1; thresh = 4'd15; m_ready = 1'b1;
    cyc(2);
    check("ar_count_pre", pop_count, 2);
    #3;
    rst = 1'b0;
    #1;
    check("ar_valid", m_valid, 0);
    check("ar_count", pop_count, 0);
    check("ar_pop", pq_pop, 0);
    cyc(2);
    rst = 1'b1;
    cyc(6);
    check("ar_recount", pop_count, 2);
    check("ar_idle", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pq_pop_stream.md
# pq_pop_stream

Consumer-side reader for the shift-register priority queue. It watches the queue head (lowest key), issues `pop` when the head is eligible, and delivers popped key-value pairs downstream on a valid/ready stream through a 2-entry output buffer. Eligibility is gated by an enable and a key threshold, so the block can also act as a release-by-deadline scheduler. It sits between the queue's `kvo/pop/empty` side and any stream consumer; the queue's push side is owned elsewhere.

## Interface
- `KW`, 4, key width in bits
- `VW`, 4, value width in bits
- `CW`, 16, width of the pop counter
- `KEYINF`, all ones (KW bits), key value that marks an empty queue slot

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pq_kvo`  in  KW+VW  queue head; key in `[KW+VW-1:VW]`, value in `[VW-1:0]`
- `pq_empty`  in  1  queue empty flag
- `pq_pop`  out  1  pop request to the queue; combinational
- `en`  in  1  release enable
- `thresh`  in  KW  release threshold; the head is eligible only when its key is `<= thresh` (unsigned)
- `flush`  in  1  synchronous clear of the output buffer
- `m_valid`  out  1  output stream valid; registered
- `m_ready`  in  1  output stream ready
- `m_kv`  out  KW+VW  output key-value pair; registered
- `pop_count`  out  CW  count of pops issued since reset; wraps at 2^CW

## Operation
- **Head eligibility:** the head is eligible when `en`, `!pq_empty`, head key `!= KEYINF`, and head key `<= thresh` all hold.
- **Buffer states:** the output buffer is a 2-entry FIFO with state `S0` (0 entries), `S1` (1 entry) or `S2` (2 entries).
  - `m_valid` = (state != `S0`).
  - `m_kv` = oldest entry.
- **Pop rule:**
  - `pq_pop` = eligible && (state != `S2` || `m_ready`) && `!flush`.
  - In `S2`, `pq_pop` therefore depends combinationally on `m_ready`. This path is permitted and documented.
- **Capture:** when `pq_pop` = 1, `pq_kvo` is written into the buffer at the same edge.
- **Dequeue:** when `m_valid && m_ready`, the oldest entry is removed at the edge.
- **State transitions** (p = pop, d = dequeue):
  - `S0`: p → `S1`.
  - `S1`: p and not d → `S2`; d and not p → `S0`; p and d → `S1`, with the new entry becoming the head.
  - `S2`: d and not p → `S1`; p and d → `S2`. p without d cannot occur.
- **Flush:** `flush` = 1 forces state `S0` at the next edge and drops both entries.
  - `pq_pop` is held at 0 during the flush cycle.
  - `pop_count` is not decremented.
- **Pop counter:** `pop_count` increments by 1 on every edge where `pq_pop` = 1; it wraps from 2^CW−1 to 0.
- **Ordering:** entries leave in pop order. Because the queue delivers its lowest key first, `m_kv` keys are non-decreasing while nothing is pushed. Pushes of smaller keys between pops may legitimately break this.
- **Threshold and enable changes:** these take effect in the same cycle, since eligibility is combinational. Entries already buffered are not recalled.

## Timing
- **Reset** (`rst` = 0, asynchronous): state `S0`, `m_valid` = 0, `m_kv` = 0, `pop_count` = 0. While `rst` = 0, `pq_pop` = 0.
  - On release, the first pop can occur at the first rising edge at which the head is eligible.
- **Reset mid-operation:** buffered entries are lost. Entries already popped from the queue are not restored.
- **Latency:** an eligible head in cycle t is popped at edge t. `m_valid` = 1 and `m_kv` = that pair in cycle t+1.
- **Queue behaviour relied on:** the queue presents its new head in cycle t+1 after a pop at edge t. This allows back-to-back pops.
- **Throughput:** one pop and one output per cycle sustained while `m_ready` = 1.
- **Stream rule:** `m_kv` must be held stable while `m_valid && !m_ready`.
- **Simultaneous push and pop:** external pushes concurrent with `pq_pop` are allowed. The block only samples the head presented in the current cycle.

## Test plan
- **Basic drain:** after reset, queue holds keys 3, 5, 9; `en` = 1; `thresh` = 15; `m_ready` = 1 → `pq_pop` is high for 3 consecutive cycles; `m_kv` keys are 3, 5, 9 in cycles t+1..t+3; `pop_count` = 3; state returns to `S0`.
- **Threshold gating:** queue holds 2, 7; `thresh` = 4 → only 2 is popped. Raising `thresh` to 7 → 7 is popped the same cycle; `pop_count` = 2.
- **Backpressure:** queue holds 1, 2, 3; `m_ready` = 0 → exactly 2 pops, state `S2`, `pq_pop` = 0, `m_kv` holds key 1. Setting `m_ready` = 1 → a same-cycle pop of 3 and dequeue of 1; outputs 1, 2, 3 in order.
- **Flush:** in `S2` (keys 4, 6) with `flush` = 1 → `pq_pop` = 0 that cycle; `m_valid` = 0 next cycle; `pop_count` unchanged at 2.
- **Empty/KEYINF:** `pq_empty` = 1, or head key = 0xF with `KW` = 4 → `pq_pop` never asserts; `m_valid` stays 0.
- **Async reset:** assert `rst` = 0 mid-stream between clock edges → `m_valid` = 0, `pop_count` = 0 and `pq_pop` = 0 immediately, without waiting for an edge.
